// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MISS  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [31:0] MC_IDLE_ADDR   = 32'h1;
    localparam int          INDEX_BITS_DEF = 6;

endpackage

// File: rtl/icache_array.sv
// Line storage: one valid/tag/data entry per line, combinational read, one synchronous write.
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = INDEX_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    output logic                  rd_valid_o,
    output logic [29-INDEX_BITS:0] rd_tag_o,
    output logic [31:0]           rd_data_o,
    input  logic                  wr_en_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [29-INDEX_BITS:0] wr_tag_i,
    input  logic [31:0]           wr_data_i
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]          valid_q;
    logic [29-INDEX_BITS:0]    tag_q  [LINES];
    logic [31:0]               data_q [LINES];

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // NOTE: tag/data are RAM-like and deliberately not reset; valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache top: miss FSM, pending address and registered outputs.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = INDEX_BITS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_e,
    input  logic [31:0] if_pc,
    input  logic        flush,
    output logic [31:0] inst,
    output logic        inst_ok,
    output logic [31:0] mc_a,
    input  logic [31:0] mc_n,
    input  logic        mc_ok,
    input  logic [31:0] mc_ca_a
);

    state_e                 state_q, state_d;
    logic [31:0]            pend_q, pend_d;
    logic [31:0]            inst_q, inst_d;
    logic                   inst_ok_q, inst_ok_d;
    logic [31:0]            mc_a_q, mc_a_d;

    logic                   rd_valid;
    logic [29-INDEX_BITS:0] rd_tag;
    logic [31:0]            rd_data;
    logic                   wr_en;
    logic                   hit, accept, complete;
    logic                   unused_pc_lsb;

    assign unused_pc_lsb = ^if_pc[1:0];

    icache_array #(.INDEX_BITS(INDEX_BITS)) u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (if_pc[INDEX_BITS+1:2]),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (wr_en),
        .wr_idx_i   (pend_q[INDEX_BITS+1:2]),
        .wr_tag_i   (pend_q[31:INDEX_BITS+2]),
        .wr_data_i  (mc_n)
    );

    assign hit      = rd_valid && (rd_tag == if_pc[31:INDEX_BITS+2]);
    assign accept   = (state_q == IDLE) && if_e && !flush;
    // Completions for any other address are stale leftovers and are ignored.
    assign complete = mc_ok && (mc_ca_a == pend_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept && !hit) state_d = MISS;
            MISS:    if (complete) state_d = IDLE;
                     else if (flush) state_d = DRAIN;
            DRAIN:   if (complete) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inst_d    = inst_q;
        inst_ok_d = 1'b0;
        mc_a_d    = mc_a_q;
        pend_d    = pend_q;
        wr_en     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept && hit) begin
                    inst_d    = rd_data;
                    inst_ok_d = 1'b1;
                end else if (accept) begin
                    mc_a_d = {if_pc[31:2], 2'b00};
                    pend_d = {if_pc[31:2], 2'b00};
                end
            end
            MISS, DRAIN: begin
                // A flushed fill is still written so the controller never needs a re-fetch.
                if (complete) begin
                    wr_en  = 1'b1;
                    mc_a_d = MC_IDLE_ADDR;
                    if (state_q == MISS && !flush) begin
                        inst_d    = mc_n;
                        inst_ok_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q    <= '0;
            inst_q    <= '0;
            inst_ok_q <= 1'b0;
            mc_a_q    <= MC_IDLE_ADDR;
        end else begin
            pend_q    <= pend_d;
            inst_q    <= inst_d;
            inst_ok_q <= inst_ok_d;
            mc_a_q    <= mc_a_d;
        end
    end

    assign inst    = inst_q;
    assign inst_ok = inst_ok_q;
    assign mc_a    = mc_a_q;

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: one task per scenario.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_e = 1'b0;
    logic [31:0] if_pc = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] inst;
    logic        inst_ok;
    logic [31:0] mc_a;
    logic [31:0] mc_n = 32'h0;
    logic        mc_ok = 1'b0;
    logic [31:0] mc_ca_a = 32'h0;

    int tests_run = 0;
    int tests_failed = 0;

    icache #(.INDEX_BITS(6)) dut (
        .clk     (clk),
        .rst     (rst),
        .if_e    (if_e),
        .if_pc   (if_pc),
        .flush   (flush),
        .inst    (inst),
        .inst_ok (inst_ok),
        .mc_a    (mc_a),
        .mc_n    (mc_n),
        .mc_ok   (mc_ok),
        .mc_ca_a (mc_ca_a)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled and inputs changed 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        tests_run++; if (inst !== 32'h0) begin tests_failed++; $display("FAIL reset_inst: got %h want %h", inst, 32'h0); end
        tests_run++; if (inst_ok !== 1'b0) begin tests_failed++; $display("FAIL reset_inst_ok: got %b want 0", inst_ok); end
        tests_run++; if (mc_a !== 32'h1) begin tests_failed++; $display("FAIL reset_mc_a: got %h want %h", mc_a, 32'h1); end
        step();
        rst = 1'b1;
    endtask

    // Miss then fill one line, holding the request until inst_ok as IF would.
    task automatic fill(input logic [31:0] addr, input logic [31:0] data, input string name);
        if_e = 1'b1; if_pc = addr;
        step();
        tests_run++; if (mc_a !== addr) begin tests_failed++; $display("FAIL %s_mc_a: got %h want %h", name, mc_a, addr); end
        mc_ok = 1'b1; mc_ca_a = addr; mc_n = data;
        step();
        tests_run++; if (inst_ok !== 1'b1 || inst !== data) begin tests_failed++; $display("FAIL %s_fill: got ok=%b inst=%h want ok=1 inst=%h", name, inst_ok, inst, data); end
        mc_ok = 1'b0; if_e = 1'b0;
        step();
    endtask

    task automatic test_cold_miss();
        if_e = 1'b1; if_pc = 32'h1000;
        step();
        tests_run++; if (mc_a !== 32'h1000) begin tests_failed++; $display("FAIL cold_mc_a: got %h want %h", mc_a, 32'h1000); end
        for (int i = 0; i < 4; i++) begin
            step();
            tests_run++; if (inst_ok !== 1'b0 || mc_a !== 32'h1000) begin tests_failed++; $display("FAIL cold_wait%0d: got ok=%b mc_a=%h want ok=0 mc_a=00001000", i, inst_ok, mc_a); end
        end
        mc_ok = 1'b1; mc_ca_a = 32'h1000; mc_n = 32'h00500093;
        step();
        tests_run++; if (inst_ok !== 1'b1) begin tests_failed++; $display("FAIL cold_inst_ok: got %b want 1", inst_ok); end
        tests_run++; if (inst !== 32'h00500093) begin tests_failed++; $display("FAIL cold_inst: got %h want %h", inst, 32'h00500093); end
        tests_run++; if (mc_a !== 32'h1) begin tests_failed++; $display("FAIL cold_mc_idle: got %h want %h", mc_a, 32'h1); end
        mc_ok = 1'b0; if_e = 1'b0;
        step();
        tests_run++; if (inst_ok !== 1'b0) begin tests_failed++; $display("FAIL cold_single_pulse: got %b want 0", inst_ok); end
    endtask

    task automatic test_hit();
        if_e = 1'b1; if_pc = 32'h1000;
        for (int i = 0; i < 2; i++) begin
            step();
            tests_run++; if (inst_ok !== 1'b1 || inst !== 32'h00500093) begin tests_failed++; $display("FAIL hit%0d: got ok=%b inst=%h want ok=1 inst=00500093", i, inst_ok, inst); end
            tests_run++; if (mc_a !== 32'h1) begin tests_failed++; $display("FAIL hit%0d_mc_a: got %h want %h", i, mc_a, 32'h1); end
        end
        if_e = 1'b0;
        step();
        tests_run++; if (inst_ok !== 1'b0) begin tests_failed++; $display("FAIL hit_idle: got %b want 0", inst_ok); end
    endtask

    task automatic test_conflict();
        fill(32'h1004, 32'h00A00113, "fill_1004");
        fill(32'h1100, 32'hAAAA0001, "fill_1100");
        if_e = 1'b1; if_pc = 32'h1000;
        step();
        tests_run++; if (inst_ok !== 1'b0 || mc_a !== 32'h1000) begin tests_failed++; $display("FAIL conflict_miss: got ok=%b mc_a=%h want ok=0 mc_a=00001000", inst_ok, mc_a); end
        mc_ok = 1'b1; mc_ca_a = 32'h1000; mc_n = 32'h00500093;
        step();
        tests_run++; if (inst_ok !== 1'b1 || inst !== 32'h00500093) begin tests_failed++; $display("FAIL conflict_refill: got ok=%b inst=%h want ok=1 inst=00500093", inst_ok, inst); end
        mc_ok = 1'b0; if_pc = 32'h1004;
        step();
        tests_run++; if (inst_ok !== 1'b1 || inst !== 32'h00A00113) begin tests_failed++; $display("FAIL conflict_other_line: got ok=%b inst=%h want ok=1 inst=00a00113", inst_ok, inst); end
        if_e = 1'b0;
        step();
    endtask

    task automatic test_flush();
        if_e = 1'b1; if_pc = 32'h2000; flush = 1'b1;
        step();
        tests_run++; if (inst_ok !== 1'b0 || mc_a !== 32'h1) begin tests_failed++; $display("FAIL flush_idle: got ok=%b mc_a=%h want ok=0 mc_a=00000001", inst_ok, mc_a); end
        flush = 1'b0;
        step();
        tests_run++; if (mc_a !== 32'h2000) begin tests_failed++; $display("FAIL flush_req: got %h want %h", mc_a, 32'h2000); end
        if_e = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        tests_run++; if (inst_ok !== 1'b0 || mc_a !== 32'h2000) begin tests_failed++; $display("FAIL flush_drain_hold: got ok=%b mc_a=%h want ok=0 mc_a=00002000", inst_ok, mc_a); end
        mc_ok = 1'b1; mc_ca_a = 32'h2000; mc_n = 32'h12345678;
        step();
        tests_run++; if (inst_ok !== 1'b0 || mc_a !== 32'h1) begin tests_failed++; $display("FAIL flush_drain_done: got ok=%b mc_a=%h want ok=0 mc_a=00000001", inst_ok, mc_a); end
        mc_ok = 1'b0; if_e = 1'b1; if_pc = 32'h2000;
        step();
        tests_run++; if (inst_ok !== 1'b1 || inst !== 32'h12345678) begin tests_failed++; $display("FAIL flush_rehit: got ok=%b inst=%h want ok=1 inst=12345678", inst_ok, inst); end
        if_e = 1'b0;
        step();
    endtask

    task automatic test_stale();
        if_e = 1'b1; if_pc = 32'h3000;
        step();
        mc_ok = 1'b1; mc_ca_a = 32'h2FFC; mc_n = 32'hDEADBEEF;
        step();
        tests_run++; if (inst_ok !== 1'b0 || mc_a !== 32'h3000) begin tests_failed++; $display("FAIL stale_ignored: got ok=%b mc_a=%h want ok=0 mc_a=00003000", inst_ok, mc_a); end
        mc_ok = 1'b0;
        step();
        tests_run++; if (mc_a !== 32'h3000) begin tests_failed++; $display("FAIL stale_hold: got %h want %h", mc_a, 32'h3000); end
        flush = 1'b1; mc_ok = 1'b1; mc_ca_a = 32'h3000; mc_n = 32'hCAFEF00D;
        step();
        tests_run++; if (inst_ok !== 1'b0 || mc_a !== 32'h1) begin tests_failed++; $display("FAIL flush_with_ok: got ok=%b mc_a=%h want ok=0 mc_a=00000001", inst_ok, mc_a); end
        flush = 1'b0; mc_ok = 1'b0;
        step();
        tests_run++; if (inst_ok !== 1'b1 || inst !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL flush_with_ok_rehit: got ok=%b inst=%h want ok=1 inst=cafef00d", inst_ok, inst); end
        if_e = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_miss();
        if_e = 1'b1; if_pc = 32'h5000;
        step();
        tests_run++; if (mc_a !== 32'h5000) begin tests_failed++; $display("FAIL rst_miss_req: got %h want %h", mc_a, 32'h5000); end
        rst = 1'b0;
        #1;
        tests_run++; if (mc_a !== 32'h1 || inst_ok !== 1'b0) begin tests_failed++; $display("FAIL rst_async: got ok=%b mc_a=%h want ok=0 mc_a=00000001", inst_ok, mc_a); end
        if_pc = 32'h1004;
        #1;
        rst = 1'b1;
        step();
        tests_run++; if (inst_ok !== 1'b0 || mc_a !== 32'h1004) begin tests_failed++; $display("FAIL rst_invalidated: got ok=%b mc_a=%h want ok=0 mc_a=00001004", inst_ok, mc_a); end
        if_e = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush();
        test_stale();
        test_reset_mid_miss();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
